// File: rtl/stream_to_axi4_wr_master.sv
// Stream-to-AXI4 write master: chops a frame of total_beats stream beats into
// sequential bursts of up to BURST_LEN beats, one burst outstanding at a time.
module stream_to_axi4_wr_master #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 4,
  parameter int BURST_LEN  = 32,
  parameter int ADDR_STEP  = 8,
  parameter int AXI_ID     = 0
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           total_beats,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ID_WIDTH-1:0]   axi_awid,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [8:0]            axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic                  axi_wlast,
  input  logic [ID_WIDTH-1:0]   axi_bid,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           remain_q;
  logic [8:0]            cur_len_q;
  logic [8:0]            beat_cnt_q;
  logic [8:0]            burst_len_w;
  logic [ADDR_WIDTH-1:0] burst_bytes;
  logic                  in_w;
  logic                  aw_fire;
  logic                  w_fire;
  logic                  b_fire;
  logic                  last_beat;

  assign burst_len_w = (remain_q > 32'(BURST_LEN)) ? 9'(BURST_LEN) : remain_q[8:0];
  assign burst_bytes = ADDR_WIDTH'(cur_len_q) * ADDR_WIDTH'(ADDR_STEP);

  assign in_w      = (state == S_W);
  assign last_beat = (beat_cnt_q == cur_len_q - 9'd1);
  assign aw_fire   = axi_awvalid && axi_awready;
  assign w_fire    = axi_wvalid && axi_wready;
  assign b_fire    = axi_bvalid && axi_bready;

  // W channel is a straight pass-through of the stream, gated by state
  assign s_ready    = in_w && axi_wready;
  assign axi_wvalid = in_w && s_valid;
  assign axi_wdata  = in_w ? s_data : '0;
  assign axi_wlast  = in_w && last_beat;
  assign axi_awid   = ID_WIDTH'(AXI_ID);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = (total_beats != '0) ? S_AW : S_DONE;
      S_AW:   if (aw_fire) state_nxt = S_W;
      S_W:    if (w_fire && last_beat) state_nxt = S_B;
      S_B:    if (b_fire) state_nxt = (remain_q != '0) ? S_AW : S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remain_q    <= '0;
      cur_len_q   <= '0;
      beat_cnt_q  <= '0;
      axi_awaddr  <= '0;
      axi_awlen   <= '0;
      axi_awvalid <= 1'b0;
      axi_bready  <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start && total_beats != '0) begin
            addr_q   <= base_addr;
            remain_q <= total_beats;
            error    <= 1'b0;
          end
        end
        S_AW: begin
          // first AW cycle only loads the request; valid rises one cycle later
          if (!axi_awvalid) begin
            axi_awvalid <= 1'b1;
            axi_awaddr  <= addr_q;
            axi_awlen   <= burst_len_w;
          end else if (axi_awready) begin
            axi_awvalid <= 1'b0;
            cur_len_q   <= axi_awlen;
            beat_cnt_q  <= '0;
          end
        end
        S_W: begin
          if (w_fire) begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
            if (last_beat) begin
              remain_q <= remain_q - 32'(cur_len_q);
              addr_q   <= addr_q + burst_bytes;
            end
          end
        end
        S_B: begin
          if (!axi_bready) begin
            axi_bready <= 1'b1;
          end else if (axi_bvalid) begin
            axi_bready <= 1'b0;
            if (axi_bresp != 2'b00 || axi_bid != ID_WIDTH'(AXI_ID)) error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_to_axi4_wr_master.sv
// Randomized bench for stream_to_axi4_wr_master: a frame-level model predicts
// bursts, beat data and status; literal checks pin the directed scenarios.
module tb_stream_to_axi4_wr_master;

  localparam int AW = 27;
  localparam int DW = 256;
  localparam int IW = 4;
  localparam int BL = 32;
  localparam int STEP = 8;

  logic          clock;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [31:0]   total_beats;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] axi_awid;
  logic [AW-1:0] axi_awaddr;
  logic [8:0]    axi_awlen;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [DW-1:0] axi_wdata;
  logic          axi_wvalid;
  logic          axi_wready;
  logic          axi_wlast;
  logic [IW-1:0] axi_bid;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready;
  logic          busy;
  logic          done;
  logic          error;

  stream_to_axi4_wr_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
    .BURST_LEN(BL), .ADDR_STEP(STEP), .AXI_ID(0)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .base_addr(base_addr),
    .total_beats(total_beats), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wdata(axi_wdata),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
    .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready), .busy(busy), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int unsigned tag, input int unsigned idx);
    logic [DW-1:0] w;
    w = '0;
    w[31:0] = idx;
    w[DW-1:DW-32] = tag;
    return w;
  endfunction

  // stimulus knobs, owned by the main sequence
  int unsigned frame_tag = 1;
  int valid_pct = 100, aw_pct = 100, w_pct = 100, b_pct = 100;
  int stall_at = -1;
  logic [5:0] bplan[$];

  // observation logs, filled by the monitor
  logic [AW-1:0] aw_addr_log[$];
  int            aw_len_log[$];
  int            wlast_log[$];
  int            w_count = 0;
  int            done_count = 0;
  int            cyc = 0, start_cyc = 0, done_cyc = 0;

  // frame-level model
  typedef struct { logic [AW-1:0] addr; int len; } burst_t;
  burst_t      exp_q[$];
  bit          model_busy = 0, model_err = 0, outstanding = 0;
  int          done_cd = 0, cur_len = 0, beat = 0;
  int unsigned exp_idx = 0, cur_tag = 0;
  bit          prev_aw_pend = 0;
  logic [AW-1:0] prev_addr;
  logic [8:0]  prev_len;

  // handshake flags captured at the sampling edge for the slave drivers
  bit f_s_hs, f_w_hs, f_wl_hs, f_b_hs;

  task automatic model_frame(input logic [AW-1:0] base, input int unsigned total);
    logic [AW-1:0] a;
    int unsigned rem;
    int len;
    a = base;
    rem = total;
    while (rem > 0) begin
      len = (rem > BL) ? BL : int'(rem);
      exp_q.push_back('{addr: a, len: len});
      a = a + AW'(len * STEP);
      rem = rem - len;
    end
  endtask

  task automatic monitor_step();
    bit exp_done, in_w, err_set;
    f_s_hs  = s_valid && s_ready;
    f_w_hs  = axi_wvalid && axi_wready;
    f_wl_hs = f_w_hs && axi_wlast;
    f_b_hs  = axi_bvalid && axi_bready;
    if (rst) begin
      chk("rst_outputs", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, s_ready, busy, done, error}, '0);
      chk("rst_aw_fields", {axi_awaddr, axi_awlen}, '0);
      exp_q.delete();
      model_busy = 0; model_err = 0; outstanding = 0; done_cd = 0; beat = 0; prev_aw_pend = 0;
      f_s_hs = 0; f_w_hs = 0; f_wl_hs = 0; f_b_hs = 0;
      return;
    end
    exp_done = 0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) begin exp_done = 1; model_busy = 0; end
    end
    in_w = outstanding && beat < cur_len;
    chk("busy", busy, model_busy);
    chk("done", done, exp_done);
    chk("error", error, model_err);
    chk("s_ready", s_ready, in_w && axi_wready);
    chk("wvalid", axi_wvalid, in_w && s_valid);
    chk("wlast", axi_wlast, in_w && beat == cur_len - 1);
    if (done) begin done_count++; done_cyc = cyc; end
    if (axi_awvalid) begin
      chk("awid", axi_awid, 0);
      chk("aw_unexpected", outstanding || exp_q.size() == 0, 0);
      if (exp_q.size() > 0) begin
        chk("awaddr", axi_awaddr, exp_q[0].addr);
        chk("awlen", axi_awlen, exp_q[0].len);
      end
      if (prev_aw_pend) chk("aw_stable", {axi_awaddr, axi_awlen}, {prev_addr, prev_len});
    end else if (prev_aw_pend) begin
      chk("aw_dropped", axi_awvalid, 1);
    end
    prev_aw_pend = axi_awvalid && !axi_awready;
    prev_addr = axi_awaddr;
    prev_len  = axi_awlen;
    if (axi_awvalid && axi_awready && exp_q.size() > 0) begin
      aw_addr_log.push_back(axi_awaddr);
      aw_len_log.push_back(int'(axi_awlen));
      cur_len = exp_q[0].len;
      exp_q.pop_front();
      outstanding = 1;
      beat = 0;
    end
    if (axi_wvalid) chk("wdata_pass", axi_wdata, s_data);
    if (f_w_hs) begin
      chk("wdata_seq", axi_wdata, mk_word(cur_tag, exp_idx));
      if (axi_wlast) wlast_log.push_back(int'(exp_idx));
      exp_idx++;
      beat++;
      w_count++;
    end
    err_set = 0;
    if (f_b_hs) begin
      chk("b_unexpected", outstanding && beat == cur_len, 1);
      if (axi_bresp != 2'b00 || axi_bid != '0) err_set = 1;
      outstanding = 0;
      if (exp_q.size() == 0) done_cd = 2;
    end
    if (err_set) model_err = 1;
    if (start && !model_busy) begin
      model_busy = 1;
      start_cyc = cyc;
      cur_tag = frame_tag;
      exp_idx = 0;
      if (total_beats != 0) begin
        model_err = 0;
        model_frame(base_addr, total_beats);
      end else begin
        done_cd = 2;
      end
    end
  endtask

  // monitor on the falling edge, slave/source drivers just after the rising edge
  initial begin
    int unsigned drv_tag, src_idx;
    int pending, stall_cnt;
    bit stall_fired;
    drv_tag = 0; src_idx = 0; pending = 0; stall_cnt = 0; stall_fired = 0;
    s_valid = 0; s_data = '0; axi_awready = 0; axi_wready = 0;
    axi_bvalid = 0; axi_bresp = 2'b00; axi_bid = '0;
    forever begin
      @(negedge clock);
      cyc++;
      monitor_step();
      @(posedge clock);
      #1;
      if (rst) begin
        axi_bvalid = 0; pending = 0;
      end else begin
        if (f_s_hs) src_idx++;
        if (f_wl_hs) pending++;
        if (f_b_hs) begin axi_bvalid = 0; pending--; end
      end
      if (frame_tag != drv_tag) begin
        drv_tag = frame_tag; src_idx = 0; stall_fired = 0;
      end
      s_data  = mk_word(drv_tag, src_idx);
      s_valid = ($urandom_range(0, 99) < valid_pct);
      if (stall_at >= 0 && int'(src_idx) == stall_at && !stall_fired) begin
        stall_cnt = 3; stall_fired = 1;
      end
      if (stall_cnt > 0) begin axi_wready = 0; stall_cnt--; end
      else axi_wready = ($urandom_range(0, 99) < w_pct);
      axi_awready = ($urandom_range(0, 99) < aw_pct);
      if (!axi_bvalid && pending > 0 && $urandom_range(0, 99) < b_pct) begin
        axi_bvalid = 1;
        if (bplan.size() > 0) {axi_bid, axi_bresp} = bplan.pop_front();
        else {axi_bid, axi_bresp} = 6'b0;
      end
    end
  end

  task automatic clear_logs();
    aw_addr_log.delete(); aw_len_log.delete(); wlast_log.delete(); w_count = 0;
  endtask

  task automatic wait_done(input int limit);
    int d0, n;
    d0 = done_count; n = 0;
    while (done_count == d0 && n < limit) begin @(posedge clock); n++; end
    if (done_count == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int unsigned total, input bit spurious);
    clear_logs();
    frame_tag++;
    @(posedge clock); #1;
    base_addr = base; total_beats = total; start = 1;
    @(posedge clock); #1;
    start = 0;
    if (spurious) begin
      repeat (2) @(posedge clock);
      #1;
      base_addr = '0; total_beats = 7; start = 1;
      @(posedge clock); #1;
      start = 0;
    end
    wait_done(5000);
    @(posedge clock);
  endtask

  task automatic set_modes(input int v, input int a, input int w, input int b);
    valid_pct = v; aw_pct = a; w_pct = w; b_pct = b;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1; start = 0; base_addr = '0; total_beats = '0;
    repeat (3) @(posedge clock);
    #1 rst = 0;
    @(posedge clock);

    // two full bursts, no backpressure
    set_modes(100, 100, 100, 100);
    d0 = done_count;
    run_frame(27'h100, 64, 0);
    chk("t1_aw_count", aw_addr_log.size(), 2);
    if (aw_addr_log.size() == 2) begin
      chk("t1_addr0", aw_addr_log[0], 27'h100);
      chk("t1_addr1", aw_addr_log[1], 27'h200);
      chk("t1_len0", aw_len_log[0], 32);
      chk("t1_len1", aw_len_log[1], 32);
    end
    chk("t1_wlast_count", wlast_log.size(), 2);
    if (wlast_log.size() == 2) begin
      chk("t1_wlast0", wlast_log[0], 31);
      chk("t1_wlast1", wlast_log[1], 63);
    end
    chk("t1_done_pulses", done_count - d0, 1);
    chk("t1_error", error, 0);

    // short final burst
    run_frame(27'h100, 40, 0);
    chk("t2_aw_count", aw_addr_log.size(), 2);
    if (aw_addr_log.size() == 2) begin
      chk("t2_addr1", aw_addr_log[1], 27'h200);
      chk("t2_len1", aw_len_log[1], 8);
    end
    if (wlast_log.size() == 2) chk("t2_wlast1", wlast_log[1], 39);
    else chk("t2_wlast_count", wlast_log.size(), 2);

    // empty frame
    run_frame(27'h100, 0, 0);
    chk("t3_aw_count", aw_addr_log.size(), 0);
    chk("t3_done_latency", done_cyc - start_cyc, 2);

    // gaps, random readiness and a forced 3-cycle wready stall
    set_modes(60, 50, 70, 50);
    stall_at = 10;
    run_frame(27'h2000, 100, 0);
    stall_at = -1;
    chk("t4_beats", w_count, 100);
    chk("t4_wlast_count", wlast_log.size(), 4);
    if (wlast_log.size() == 4) chk("t4_wlast3", wlast_log[3], 99);

    // slave error on the first burst does not abort the frame
    bplan.push_back(6'b0000_10);
    run_frame(27'h100, 64, 0);
    chk("t5_aw_count", aw_addr_log.size(), 2);
    chk("t5_err_held", error, 1);
    run_frame(27'h400, 16, 0);
    chk("t5_err_cleared", error, 0);
    bplan.push_back(6'b0101_00);
    run_frame(27'h400, 8, 0);
    chk("t5_bid_err", error, 1);

    // reset in the middle of a burst
    set_modes(100, 100, 100, 100);
    clear_logs();
    frame_tag++;
    @(posedge clock); #1;
    base_addr = 27'h300; total_beats = 64; start = 1;
    @(posedge clock); #1;
    start = 0;
    begin
      int n;
      n = 0;
      while (w_count < 10 && n < 200) begin @(posedge clock); n++; end
      if (w_count < 10) chk("t6_beat_timeout", 0, 1);
    end
    #1 rst = 1;
    #1 chk("t6_rst_immediate", {busy, axi_wvalid, s_ready, axi_awvalid}, 0);
    repeat (2) @(posedge clock);
    #1 rst = 0;
    run_frame(27'h1000, 40, 0);
    chk("t6_aw_count", aw_addr_log.size(), 2);
    if (aw_addr_log.size() == 2) begin
      chk("t6_addr0", aw_addr_log[0], 27'h1000);
      chk("t6_len0", aw_len_log[0], 32);
      chk("t6_addr1", aw_addr_log[1], 27'h1100);
    end

    // address wrap at the top of the space, with an ignored mid-frame start
    set_modes(80, 60, 80, 60);
    run_frame(27'h7FF_FFC0, 40, 1);
    if (aw_addr_log.size() == 2) chk("t7_wrap_addr", aw_addr_log[1], 27'h0C0);
    else chk("t7_aw_count", aw_addr_log.size(), 2);

    // random frames
    for (int i = 0; i < 6; i++) begin
      set_modes($urandom_range(30, 100), $urandom_range(30, 100),
                $urandom_range(30, 100), $urandom_range(30, 100));
      if ($urandom_range(0, 3) == 0) bplan.push_back(6'($urandom_range(1, 3)));
      run_frame(AW'($urandom), $urandom_range(1, 150), 1);
    end

    repeat (5) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_to_axi4_wr_master.md
Name: stream_to_axi4_wr_master

Overview:
- Upstream feeder of the AXI4-to-DDR-native bridge.
- Takes a valid/ready pixel/data stream and a frame descriptor (base address, beat count).
- Issues sequential AXI4 write bursts of BURST_LEN beats (shorter final burst), one burst outstanding at a time.
- Waits for each write response before starting the next burst; reports busy/done/error to the VDMA control logic.

Parameters:
ADDR_WIDTH, 27, AXI/DDR address width
DATA_WIDTH, 256, stream and AXI data width
ID_WIDTH, 4, AXI ID width
BURST_LEN, 32, maximum beats per burst (1..255)
ADDR_STEP, 8, address increment per beat (DDR native units)
AXI_ID, 0, constant awid value

Ports:
clock  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  pulse; latch descriptor and begin frame
base_addr  in  ADDR_WIDTH  frame start address
total_beats  in  32  frame length in beats
s_data  in  DATA_WIDTH  stream data
s_valid  in  1  stream valid
s_ready  out  1  stream ready
axi_awid  out  ID_WIDTH  write ID (=AXI_ID)
axi_awaddr  out  ADDR_WIDTH  burst address
axi_awlen  out  9  beats in burst
axi_awvalid  out  1  AW valid
axi_awready  in  1  AW ready
axi_wdata  out  DATA_WIDTH  write data
axi_wvalid  out  1  W valid
axi_wready  in  1  W ready
axi_wlast  out  1  last beat of burst
axi_bid  in  ID_WIDTH  response ID
axi_bresp  in  2  response code
axi_bvalid  in  1  B valid
axi_bready  out  1  B ready
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame completion
error  out  1  sticky; bresp!=0 or bid!=AXI_ID seen

Behaviour:
- Reset: state IDLE; axi_awvalid, axi_wvalid, axi_wlast, axi_bready, s_ready, busy, done, error = 0; axi_awaddr, axi_awlen = 0; counters = 0.
- States: IDLE, AW, W, B, DONE.
- IDLE
  - start=1 with total_beats>0: latch base_addr into addr reg, total_beats into remain reg, clear error → AW.
  - start=1 with total_beats=0: → DONE, no AXI traffic.
  - start is ignored in every state except IDLE.
- AW
  - axi_awvalid=1 (registered; high on the cycle after entry).
  - axi_awaddr = addr reg; axi_awlen = min(remain, BURST_LEN).
  - axi_awlen carries the beat count, not beats-1; this matches the DDR bridge convention.
  - awaddr/awlen are held stable while awvalid=1.
  - On awvalid&&awready: drop awvalid, store cur_len, clear beat_cnt → W.
- W (combinational pass-through)
  - axi_wdata = s_data; axi_wvalid = s_valid; s_ready = axi_wready; all only while in W, else s_ready=0 and wvalid=0.
  - Beat accepted on wvalid&&wready: beat_cnt++.
  - axi_wlast = (beat_cnt == cur_len-1) while in W.
  - Beat with wlast accepted: remain -= cur_len; addr += cur_len*ADDR_STEP, wrapping modulo 2^ADDR_WIDTH → B.
- B
  - axi_bready=1 (registered).
  - On bvalid&&bready: set error if bresp!=2'b00 or bid!=AXI_ID.
  - Then → AW if remain>0, else → DONE.
  - Error does not abort the frame.
- DONE: done=1 for exactly one cycle → IDLE.
- busy = 1 in AW/W/B/DONE, 0 in IDLE.
- Throughput: one bubble cycle min between AW entry and awvalid; W beats can stream at one per cycle.
- Stalls:
  - s_valid low mid-burst: wvalid drops, no beat counted.
  - wready low: s_ready low, stream is back-pressured.
- Simultaneous events: a start during DONE is ignored; start must be re-issued in IDLE.
- Reset mid-operation: immediate return to reset values. The downstream bridge shares this reset, so no partial-burst recovery is required.
- Widths: remain 32-bit, never underflows since cur_len<=remain; cur_len 9-bit.

Test Plan:
- base_addr=0x100, total_beats=64, BURST_LEN=32, s_valid always 1, awready/wready/bready immediate -> two bursts: awaddr 0x100 then 0x200, awlen=32 each; wlast on beats 31 and 63; one done pulse; error=0.
- total_beats=40 -> bursts awlen=32 then awlen=8 at 0x100+256; wlast on the 8th beat of the second burst.
- total_beats=0, start -> done pulse 2 cycles after start; awvalid never asserts.
- Random s_valid gaps plus wready low 3 cycles mid-burst -> beats unchanged in order; no duplicates or drops; data sequence 0..N-1 matches.
- bresp=2'b10 on the first of two bursts -> second burst still issued; error=1 after the first B and held after done; cleared by next start.
- rst asserted in W after 10 beats -> all outputs 0 the same cycle; a fresh start afterwards begins at the new base_addr with full awlen.
